// File: rtl/mux2_share_arbiter.sv
// Round-robin owner of a shared WIDTH-bit 2:1 mux: one-hot grants, bounded hold
// while the other side waits, and a registered output beat with valid/owner tags.
module mux2_share_arbiter #(
  parameter int WIDTH    = 2,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gntA,
  output logic             gntB,
  output logic             c,
  output logic [WIDTH-1:0] z,
  output logic             valid,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD_MAX);

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             last_q, last_d;   // 0 = A served last, 1 = B
  logic [WIDTH-1:0] z_q, z_d;
  logic             valid_q, valid_d;
  logic             owner_q, owner_d;

  // Owner-relative view so both OWN states share one body of logic.
  logic             own_b;
  logic             req_own;
  logic             req_oth;
  logic [WIDTH-1:0] sel_data;
  state_t           other_state;

  assign own_b       = (state_q == OWN_B);
  assign req_own     = own_b ? reqB : reqA;
  assign req_oth     = own_b ? reqA : reqB;
  assign sel_data    = own_b ? b : a;
  assign other_state = own_b ? OWN_A : OWN_B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      last_q  <= 1'b1;
      z_q     <= '0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    z_d     = z_q;
    valid_d = 1'b0;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        count_d = 4'd0;
        if (reqA && reqB)  state_d = last_q ? OWN_A : OWN_B;
        else if (reqA)     state_d = OWN_A;
        else if (reqB)     state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        if (req_own) begin
          z_d     = sel_data;
          valid_d = 1'b1;
          owner_d = own_b;
          // A saturated count also qualifies, so a late request preempts at once.
          if (req_oth && (count_q >= HOLD_C - 4'd1)) begin
            state_d = other_state;
            count_d = 4'd0;
            last_d  = own_b;
          end else if (count_q < HOLD_C) begin
            count_d = count_q + 4'd1;
          end
        end else begin
          count_d = 4'd0;
          last_d  = own_b;
          state_d = req_oth ? other_state : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gntA  = (state_q == OWN_A);
  assign gntB  = (state_q == OWN_B);
  assign c     = (state_q == OWN_B);
  assign z     = z_q;
  assign valid = valid_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed and randomized bench for mux2_share_arbiter against an owner/count
// reference model kept in plain integers.
module tb_mux2_share_arbiter;

  localparam int W    = 2;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         reqA = 1'b0, reqB = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         gntA, gntB, c, valid, owner;
  logic [W-1:0] z;

  int errors = 0;
  int checks = 0;

  // Reference model: own = -1 idle, 0 = A, 1 = B.
  int           m_own, m_cnt, m_last;
  logic [W-1:0] m_z;
  bit           m_valid, m_owner;

  mux2_share_arbiter #(.WIDTH(W), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset), .reqA(reqA), .reqB(reqB), .a(a), .b(b),
    .gntA(gntA), .gntB(gntB), .c(c), .z(z), .valid(valid), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_z = '0; m_valid = 0; m_owner = 0;
  endtask

  task automatic model_step();
    bit           rq [2];
    logic [W-1:0] d  [2];
    int           o;
    rq[0] = reqA; rq[1] = reqB; d[0] = a; d[1] = b;
    if (m_own < 0) begin
      m_valid = 0;
      if (rq[0] && rq[1]) m_own = 1 - m_last;
      else if (rq[0])     m_own = 0;
      else if (rq[1])     m_own = 1;
    end else begin
      o = m_own;
      if (rq[o]) begin
        m_z = d[o]; m_valid = 1; m_owner = (o == 1);
        if (rq[1-o] && m_cnt + 1 >= HOLD) begin
          m_own = 1 - o; m_cnt = 0; m_last = o;
        end else begin
          m_cnt = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
        end
      end else begin
        m_valid = 0; m_cnt = 0; m_last = o;
        m_own = rq[1-o] ? 1 - o : -1;
      end
    end
  endtask

  task automatic compare_all();
    check("gntA",  32'(gntA),  32'(m_own == 0));
    check("gntB",  32'(gntB),  32'(m_own == 1));
    check("c",     32'(c),     32'(m_own == 1));
    check("valid", 32'(valid), 32'(m_valid));
    check("owner", 32'(owner), 32'(m_owner));
    check("z",     32'(z),     32'(m_z));
    check("onehot", 32'(gntA & gntB), 32'(0));
  endtask

  task automatic cycle(input bit ra, input bit rb, input logic [W-1:0] da, input logic [W-1:0] db);
    reqA = ra; reqB = rb; a = da; b = db;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous pulse landing between edges; outputs must clear before any edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 reset = 1'b0;
  endtask

  initial begin
    bit           ra, rb;
    logic [W-1:0] pa, pb;
    model_reset();
    #12;
    compare_all();
    reset = 1'b0;
    @(posedge clk); #1;
    model_step(); compare_all();

    // Reset mid-burst, then a tie goes to A.
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b10, 2'b00);
    check("pre_reset_z", 32'(z), 32'(2'b10));
    pulse_reset();
    cycle(1, 1, 2'b01, 2'b10);
    check("tie_first_A", 32'(gntA), 32'(1));
    for (int i = 0; i < 2; i++) cycle(0, 0, 2'b00, 2'b00);

    // Single requester burst and release.
    cycle(1, 0, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b11, 2'b00);
    check("single_z", 32'(z), 32'(2'b11));
    cycle(0, 0, 2'b11, 2'b00);
    cycle(0, 0, 2'b00, 2'b00);

    // Tie alternation over three windows.
    for (int i = 0; i < 14; i++) cycle(1, 1, 2'b01, 2'b10);
    // Hand-off on release from B.
    for (int i = 0; i < 4; i++) cycle(1, 1, 2'b01, 2'b10);
    cycle(gntB ? 1'b1 : 1'b0, ~gntB, 2'b01, 2'b10);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b01, 2'b10);
    for (int i = 0; i < 2; i++) cycle(0, 0, 2'b00, 2'b00);

    // Saturation then preemption.
    for (int i = 0; i < 11; i++) cycle(1, 0, 2'b01, 2'b10);
    cycle(1, 1, 2'b01, 2'b10);
    check("preempt_gntB", 32'(gntB), 32'(1));
    cycle(1, 1, 2'b01, 2'b10);
    check("preempt_zb", 32'(z), 32'(2'b10));
    for (int i = 0; i < 2; i++) cycle(0, 0, 2'b00, 2'b00);

    // All (a,b) pairs with both sides granted in turn.
    for (int i = 0; i < 16; i++) begin
      pa = W'(i >> 2); pb = W'(i & 3);
      for (int k = 0; k < 2 * HOLD + 2; k++) cycle(1, 1, pa, pb);
    end
    for (int i = 0; i < 2; i++) cycle(0, 0, 2'b00, 2'b00);

    // Randomized bursts with an occasional asynchronous reset.
    ra = 0; rb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      cycle(ra, rb, W'($urandom), W'($urandom));
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
